// File: rtl/hazard_fwd_ctrl.sv
// Hazard detection and operand forwarding for the 5-stage MIPS pipeline, plus mult/div busy tracking.
// Define HAZARD_STALL_CNT_EN to add the stall_cnt / md_stall_cnt performance counters.
module hazard_fwd_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs_D,
  input  logic [4:0]  rt_D,
  input  logic [1:0]  tuse_rs_D,
  input  logic [1:0]  tuse_rt_D,
  input  logic [31:0] rd1_D,
  input  logic [31:0] rd2_D,
  input  logic [4:0]  rs_E,
  input  logic [4:0]  rt_E,
  input  logic [31:0] rs_val_E,
  input  logic [31:0] rt_val_E,
  input  logic [4:0]  rt_M,
  input  logic [31:0] rt_val_M,
  input  logic [4:0]  A3_FWD_E,
  input  logic [1:0]  Tnew_FWD_E,
  input  logic [31:0] WD_FWD_E,
  input  logic [4:0]  A3_FWD_M,
  input  logic [1:0]  Tnew_FWD_M,
  input  logic [31:0] WD_FWD_M,
  input  logic [4:0]  A3_FWD_W,
  input  logic [31:0] WD_FWD_W,
  input  logic        md_start_E,
  input  logic        md_is_div_E,
  input  logic        md_use_D,
  output logic [31:0] fwd_rs_D,
  output logic [31:0] fwd_rt_D,
  output logic [31:0] fwd_rs_E,
  output logic [31:0] fwd_rt_E,
  output logic [31:0] fwd_rt_M,
  output logic        stall,
  output logic        en_PC,
  output logic        en_D,
  output logic        clr_E,
  output logic        md_busy
`ifdef HAZARD_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] md_stall_cnt
`endif
);

  localparam logic [CNT_W-1:0] MultLoad = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DivLoad  = CNT_W'(DIV_CYCLES);

  // Youngest ready producer wins; the use_* flags restrict which stages a consumer may see.
  function automatic logic [31:0] pick(
    input logic [4:0]  r,
    input logic [31:0] orig,
    input logic        use_e,
    input logic        use_m,
    input logic [4:0]  a3_e,
    input logic [1:0]  tnew_e,
    input logic [31:0] wd_e,
    input logic [4:0]  a3_m,
    input logic [1:0]  tnew_m,
    input logic [31:0] wd_m,
    input logic [4:0]  a3_w,
    input logic [31:0] wd_w
  );
    logic [31:0] v;
    v = orig;
    if (r != 5'd0) begin
      if (use_e && a3_e == r && tnew_e == 2'd0) begin
        v = wd_e;
      end else if (use_m && a3_m == r && tnew_m == 2'd0) begin
        v = wd_m;
      end else if (a3_w == r) begin
        v = wd_w;
      end
    end
    return v;
  endfunction

  function automatic logic hazard(
    input logic [4:0] r,
    input logic [1:0] tuse,
    input logic [4:0] a3_e,
    input logic [1:0] tnew_e,
    input logic [4:0] a3_m,
    input logic [1:0] tnew_m
  );
    logic h;
    h = 1'b0;
    if (r != 5'd0 && tuse != 2'd3) begin
      h = (a3_e == r && tnew_e > tuse) || (a3_m == r && tnew_m > tuse);
    end
    return h;
  endfunction

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_raw;
  logic             data_stall;
  logic             md_stall_raw;

  always_comb begin
    fwd_rs_D = pick(rs_D, rd1_D, 1'b1, 1'b1, A3_FWD_E, Tnew_FWD_E, WD_FWD_E,
                    A3_FWD_M, Tnew_FWD_M, WD_FWD_M, A3_FWD_W, WD_FWD_W);
    fwd_rt_D = pick(rt_D, rd2_D, 1'b1, 1'b1, A3_FWD_E, Tnew_FWD_E, WD_FWD_E,
                    A3_FWD_M, Tnew_FWD_M, WD_FWD_M, A3_FWD_W, WD_FWD_W);
    fwd_rs_E = pick(rs_E, rs_val_E, 1'b0, 1'b1, A3_FWD_E, Tnew_FWD_E, WD_FWD_E,
                    A3_FWD_M, Tnew_FWD_M, WD_FWD_M, A3_FWD_W, WD_FWD_W);
    fwd_rt_E = pick(rt_E, rt_val_E, 1'b0, 1'b1, A3_FWD_E, Tnew_FWD_E, WD_FWD_E,
                    A3_FWD_M, Tnew_FWD_M, WD_FWD_M, A3_FWD_W, WD_FWD_W);
    fwd_rt_M = pick(rt_M, rt_val_M, 1'b0, 1'b0, A3_FWD_E, Tnew_FWD_E, WD_FWD_E,
                    A3_FWD_M, Tnew_FWD_M, WD_FWD_M, A3_FWD_W, WD_FWD_W);
  end

  always_comb begin
    data_stall = hazard(rs_D, tuse_rs_D, A3_FWD_E, Tnew_FWD_E, A3_FWD_M, Tnew_FWD_M) |
                 hazard(rt_D, tuse_rt_D, A3_FWD_E, Tnew_FWD_E, A3_FWD_M, Tnew_FWD_M);
    busy_raw     = (cnt_q != '0);
    md_stall_raw = md_use_D & (md_start_E | busy_raw);
    // Reset overrides the stall path so the front end keeps fetching while the counter clears.
    stall   = ~reset & (data_stall | md_stall_raw);
    md_busy = ~reset & busy_raw;
    en_PC   = ~stall;
    en_D    = ~stall;
    clr_E   = stall;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (md_start_E) begin
      cnt_d = md_is_div_E ? DivLoad : MultLoad;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] md_stall_cnt_q, md_stall_cnt_d;

  always_comb begin
    stall_cnt_d    = stall_cnt_q + {31'd0, stall};
    md_stall_cnt_d = md_stall_cnt_q + {31'd0, md_stall_raw};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q    <= '0;
      md_stall_cnt_q <= '0;
    end else begin
      stall_cnt_q    <= stall_cnt_d;
      md_stall_cnt_q <= md_stall_cnt_d;
    end
  end

  assign stall_cnt    = stall_cnt_q;
  assign md_stall_cnt = md_stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Self-checking bench for hazard_fwd_ctrl: directed scenarios plus randomized traffic vs a behavioural model.
module tb_hazard_fwd_ctrl;

  logic        clk;
  logic        reset;
  logic [4:0]  rs_D, rt_D, rs_E, rt_E, rt_M;
  logic [1:0]  tuse_rs_D, tuse_rt_D;
  logic [31:0] rd1_D, rd2_D, rs_val_E, rt_val_E, rt_val_M;
  logic [4:0]  A3_FWD_E, A3_FWD_M, A3_FWD_W;
  logic [1:0]  Tnew_FWD_E, Tnew_FWD_M;
  logic [31:0] WD_FWD_E, WD_FWD_M, WD_FWD_W;
  logic        md_start_E, md_is_div_E, md_use_D;
  logic [31:0] fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M;
  logic        stall, en_PC, en_D, clr_E, md_busy;
`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_cnt, md_stall_cnt;
`endif

  hazard_fwd_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .rs_D        (rs_D),
    .rt_D        (rt_D),
    .tuse_rs_D   (tuse_rs_D),
    .tuse_rt_D   (tuse_rt_D),
    .rd1_D       (rd1_D),
    .rd2_D       (rd2_D),
    .rs_E        (rs_E),
    .rt_E        (rt_E),
    .rs_val_E    (rs_val_E),
    .rt_val_E    (rt_val_E),
    .rt_M        (rt_M),
    .rt_val_M    (rt_val_M),
    .A3_FWD_E    (A3_FWD_E),
    .Tnew_FWD_E  (Tnew_FWD_E),
    .WD_FWD_E    (WD_FWD_E),
    .A3_FWD_M    (A3_FWD_M),
    .Tnew_FWD_M  (Tnew_FWD_M),
    .WD_FWD_M    (WD_FWD_M),
    .A3_FWD_W    (A3_FWD_W),
    .WD_FWD_W    (WD_FWD_W),
    .md_start_E  (md_start_E),
    .md_is_div_E (md_is_div_E),
    .md_use_D    (md_use_D),
    .fwd_rs_D    (fwd_rs_D),
    .fwd_rt_D    (fwd_rt_D),
    .fwd_rs_E    (fwd_rs_E),
    .fwd_rt_E    (fwd_rt_E),
    .fwd_rt_M    (fwd_rt_M),
    .stall       (stall),
    .en_PC       (en_PC),
    .en_D        (en_D),
    .clr_E       (clr_E),
    .md_busy     (md_busy)
`ifdef HAZARD_STALL_CNT_EN
    ,
    .stall_cnt   (stall_cnt),
    .md_stall_cnt(md_stall_cnt)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state: cycles of mult/div work still outstanding, and stall tallies.
  int          m_remaining = 0;
  int unsigned m_stalls    = 0;
  int unsigned m_md_stalls = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit expired, got no summary, required completion");
    $fatal(1);
  end

  function automatic logic [31:0] m_fwd(input logic [4:0] r, input logic [31:0] orig,
                                        input int first_stage);
    logic [4:0]  a3 [3];
    int          tn [3];
    logic [31:0] wd [3];
    a3 = '{A3_FWD_E, A3_FWD_M, A3_FWD_W};
    tn = '{int'(Tnew_FWD_E), int'(Tnew_FWD_M), 0};
    wd = '{WD_FWD_E, WD_FWD_M, WD_FWD_W};
    if (r == 5'd0) return orig;
    for (int s = first_stage; s < 3; s++) begin
      if (a3[s] == r && tn[s] == 0) return wd[s];
    end
    return orig;
  endfunction

  function automatic bit m_data_stall();
    logic [4:0] regs  [2];
    int         tuses [2];
    regs  = '{rs_D, rt_D};
    tuses = '{int'(tuse_rs_D), int'(tuse_rt_D)};
    for (int i = 0; i < 2; i++) begin
      if (regs[i] != 5'd0 && tuses[i] != 3) begin
        if (A3_FWD_E == regs[i] && int'(Tnew_FWD_E) > tuses[i]) return 1'b1;
        if (A3_FWD_M == regs[i] && int'(Tnew_FWD_M) > tuses[i]) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic bit m_md_stall();
    return md_use_D && (md_start_E || m_remaining > 0);
  endfunction

  function automatic bit m_stall();
    return !reset && (m_data_stall() || m_md_stall());
  endfunction

  function automatic bit m_busy();
    return !reset && m_remaining > 0;
  endfunction

  task automatic model_edge();
    if (reset) begin
      m_remaining = 0;
      m_stalls    = 0;
      m_md_stalls = 0;
    end else begin
      if (m_stall())    m_stalls++;
      if (m_md_stall()) m_md_stalls++;
      if (md_start_E)            m_remaining = md_is_div_E ? 10 : 5;
      else if (m_remaining > 0)  m_remaining--;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clear_inputs();
    {rs_D, rt_D, rs_E, rt_E, rt_M} = '0;
    tuse_rs_D = 2'd3; tuse_rt_D = 2'd3;
    rd1_D = 32'h1111_0001; rd2_D = 32'h1111_0002;
    rs_val_E = 32'h2222_0001; rt_val_E = 32'h2222_0002; rt_val_M = 32'h3333_0002;
    {A3_FWD_E, A3_FWD_M, A3_FWD_W} = '0;
    Tnew_FWD_E = 2'd0; Tnew_FWD_M = 2'd0;
    WD_FWD_E = 32'hE; WD_FWD_M = 32'hA; WD_FWD_W = 32'hB;
    md_start_E = 1'b0; md_is_div_E = 1'b0; md_use_D = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    md_use_D = 1'b1; md_start_E = 1'b1;
    rs_D = 5'd4; tuse_rs_D = 2'd0; A3_FWD_E = 5'd4; Tnew_FWD_E = 2'd2;
    #1;
    n_vec++;
    if (stall !== 1'b0 || clr_E !== 1'b0 || en_PC !== 1'b1 || en_D !== 1'b1 ||
        md_busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got stall=%b clr_E=%b en_PC=%b en_D=%b md_busy=%b, required 0 0 1 1 0",
               stall, clr_E, en_PC, en_D, md_busy);
    end
    tick();
    tick();
    clear_inputs();
    reset = 1'b0;
    #1;
    n_vec++;
    if (md_busy !== 1'b0 || stall !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: got md_busy=%b stall=%b, required 0 0", md_busy, stall);
    end
`ifdef HAZARD_STALL_CNT_EN
    n_vec++;
    if (stall_cnt !== 32'd0 || md_stall_cnt !== 32'd0) begin
      n_err++;
      $display("FAIL reset_counters: got %0d/%0d, required 0/0", stall_cnt, md_stall_cnt);
    end
`endif
  endtask

  task automatic test_fwd_from_e();
    clear_inputs();
    A3_FWD_E = 5'd8; Tnew_FWD_E = 2'd0; WD_FWD_E = 32'h1234;
    A3_FWD_M = 5'd8; Tnew_FWD_M = 2'd0; WD_FWD_M = 32'h5555;
    A3_FWD_W = 5'd8; WD_FWD_W = 32'h7777;
    rs_D = 5'd8; rs_E = 5'd8; rt_M = 5'd8; tuse_rs_D = 2'd0;
    #1;
    n_vec++;
    if (fwd_rs_D !== 32'h1234 || stall !== 1'b0) begin
      n_err++;
      $display("FAIL fwd_e_wins: got fwd_rs_D=%h stall=%b, required 00001234 0", fwd_rs_D, stall);
    end
    n_vec++;
    if (fwd_rs_E !== 32'h5555) begin
      n_err++;
      $display("FAIL fwd_e_from_m: got %h, required 00005555", fwd_rs_E);
    end
    n_vec++;
    if (fwd_rt_M !== 32'h7777) begin
      n_err++;
      $display("FAIL fwd_m_from_w: got %h, required 00007777", fwd_rt_M);
    end
    // A not-yet-ready E producer must be skipped in favour of M.
    Tnew_FWD_E = 2'd1;
    #1;
    n_vec++;
    if (fwd_rs_D !== 32'h5555) begin
      n_err++;
      $display("FAIL fwd_skip_unready: got %h, required 00005555", fwd_rs_D);
    end
  endtask

  task automatic test_load_use();
    clear_inputs();
    A3_FWD_E = 5'd9; Tnew_FWD_E = 2'd2; rt_D = 5'd9; tuse_rt_D = 2'd1;
    #1;
    n_vec++;
    if (stall !== 1'b1 || clr_E !== 1'b1 || en_PC !== 1'b0 || en_D !== 1'b0) begin
      n_err++;
      $display("FAIL load_use_stall: got stall=%b clr_E=%b en_PC=%b en_D=%b, required 1 1 0 0",
               stall, clr_E, en_PC, en_D);
    end
    tuse_rt_D = 2'd2;
    #1;
    n_vec++;
    if (stall !== 1'b0 || en_PC !== 1'b1) begin
      n_err++;
      $display("FAIL load_use_nostall: got stall=%b en_PC=%b, required 0 1", stall, en_PC);
    end
    A3_FWD_E = 5'd0; A3_FWD_M = 5'd9; Tnew_FWD_M = 2'd3; tuse_rt_D = 2'd3;
    #1;
    n_vec++;
    if (stall !== 1'b0) begin
      n_err++;
      $display("FAIL tuse3_nostall: got stall=%b, required 0", stall);
    end
  endtask

  task automatic test_reg0();
    clear_inputs();
    A3_FWD_M = 5'd0; Tnew_FWD_M = 2'd0; WD_FWD_M = 32'hFFFF; rs_E = 5'd0; rs_val_E = 32'd0;
    A3_FWD_E = 5'd0; Tnew_FWD_E = 2'd3; rs_D = 5'd0; tuse_rs_D = 2'd0;
    #1;
    n_vec++;
    if (fwd_rs_E !== 32'd0 || stall !== 1'b0) begin
      n_err++;
      $display("FAIL reg0: got fwd_rs_E=%h stall=%b, required 00000000 0", fwd_rs_E, stall);
    end
  endtask

  task automatic test_div_busy();
    clear_inputs();
    md_use_D = 1'b1; md_start_E = 1'b1; md_is_div_E = 1'b1;
    for (int c = 0; c <= 12; c++) begin
      #1;
      n_vec++;
      if (stall !== (c <= 10) || md_busy !== (c >= 1 && c <= 10)) begin
        n_err++;
        $display("FAIL div_busy cycle %0d: got stall=%b md_busy=%b, required %b %b",
                 c, stall, md_busy, c <= 10, c >= 1 && c <= 10);
      end
      tick();
      md_start_E = 1'b0; md_is_div_E = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    md_use_D = 1'b1; md_start_E = 1'b1;
    tick();
    md_start_E = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    n_vec++;
    if (md_busy !== 1'b0 || stall !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_during: got md_busy=%b stall=%b, required 0 0", md_busy, stall);
    end
    tick();
    reset = 1'b0;
    #1;
    n_vec++;
    if (md_busy !== 1'b0 || stall !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid_after: got md_busy=%b stall=%b, required 0 0", md_busy, stall);
    end
`ifdef HAZARD_STALL_CNT_EN
    n_vec++;
    if (stall_cnt !== 32'd0) begin
      n_err++;
      $display("FAIL reset_mid_cnt: got %0d, required 0", stall_cnt);
    end
    md_start_E = 1'b1;
    tick();
    md_start_E = 1'b0;
    tick();
    n_vec++;
    if (stall_cnt !== 32'd2 || md_stall_cnt !== 32'd2) begin
      n_err++;
      $display("FAIL stall_cnt_incr: got %0d/%0d, required 2/2", stall_cnt, md_stall_cnt);
    end
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      reset       = ($urandom_range(0, 31) == 0);
      rs_D        = 5'($urandom_range(0, 3));
      rt_D        = 5'($urandom_range(0, 3));
      rs_E        = 5'($urandom_range(0, 3));
      rt_E        = 5'($urandom_range(0, 3));
      rt_M        = 5'($urandom_range(0, 3));
      tuse_rs_D   = 2'($urandom);
      tuse_rt_D   = 2'($urandom);
      rd1_D       = $urandom; rd2_D = $urandom;
      rs_val_E    = $urandom; rt_val_E = $urandom; rt_val_M = $urandom;
      A3_FWD_E    = 5'($urandom_range(0, 3));
      A3_FWD_M    = 5'($urandom_range(0, 3));
      A3_FWD_W    = 5'($urandom_range(0, 3));
      Tnew_FWD_E  = 2'($urandom);
      Tnew_FWD_M  = 2'($urandom);
      WD_FWD_E    = $urandom; WD_FWD_M = $urandom; WD_FWD_W = $urandom;
      md_start_E  = ($urandom_range(0, 11) == 0);
      md_is_div_E = 1'($urandom);
      md_use_D    = ($urandom_range(0, 2) == 0);
      #1;
      n_vec++;
      if (fwd_rs_D !== m_fwd(rs_D, rd1_D, 0) || fwd_rt_D !== m_fwd(rt_D, rd2_D, 0)) begin
        n_err++;
        $display("FAIL rand_fwd_D %0d: got %h %h, required %h %h", i, fwd_rs_D, fwd_rt_D,
                 m_fwd(rs_D, rd1_D, 0), m_fwd(rt_D, rd2_D, 0));
      end
      n_vec++;
      if (fwd_rs_E !== m_fwd(rs_E, rs_val_E, 1) || fwd_rt_E !== m_fwd(rt_E, rt_val_E, 1) ||
          fwd_rt_M !== m_fwd(rt_M, rt_val_M, 2)) begin
        n_err++;
        $display("FAIL rand_fwd_EM %0d: got %h %h %h, required %h %h %h", i, fwd_rs_E, fwd_rt_E,
                 fwd_rt_M, m_fwd(rs_E, rs_val_E, 1), m_fwd(rt_E, rt_val_E, 1),
                 m_fwd(rt_M, rt_val_M, 2));
      end
      n_vec++;
      if (stall !== m_stall() || clr_E !== m_stall() || en_PC !== !m_stall() ||
          en_D !== !m_stall() || md_busy !== m_busy()) begin
        n_err++;
        $display("FAIL rand_ctrl %0d: got stall=%b clr_E=%b en_PC=%b en_D=%b md_busy=%b, required stall=%b md_busy=%b",
                 i, stall, clr_E, en_PC, en_D, md_busy, m_stall(), m_busy());
      end
`ifdef HAZARD_STALL_CNT_EN
      n_vec++;
      if (stall_cnt !== m_stalls || md_stall_cnt !== m_md_stalls) begin
        n_err++;
        $display("FAIL rand_cnt %0d: got %0d/%0d, required %0d/%0d", i, stall_cnt, md_stall_cnt,
                 m_stalls, m_md_stalls);
      end
`endif
      tick();
    end
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    test_reset();
    test_fwd_from_e();
    test_load_use();
    test_reg0();
    test_div_busy();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_fwd_ctrl.md
Name: hazard_fwd_ctrl

Overview:
- Central hazard and forwarding controller for the 5-stage MIPS pipeline.
- Consumes the per-stage forwarding triples (A3, Tnew, WD) published by the ID/EX, EX/MEM and MEM/WB pipeline registers.
- Produces forwarded operand values for the D, E and M stages, plus stall/flush controls.
- Owns a cycle counter that tracks the multi-cycle mult/div unit, so HI/LO consumers stall until the result is ready.

Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu start
- DIV_CYCLES, 10, busy cycles after a div/divu start
- CNT_W, 4, md busy counter width; must hold max(MULT_CYCLES, DIV_CYCLES)

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high
- rs_D, rt_D  in  5 each  D-stage source register numbers
- tuse_rs_D, tuse_rt_D  in  2 each  cycles until D instr needs rs/rt (3 = not used)
- rd1_D, rd2_D  in  32 each  GRF read data for rs_D/rt_D
- rs_E, rt_E  in  5 each  E-stage source registers
- rs_val_E, rt_val_E  in  32 each  values latched in ID/EX
- rt_M  in  5  M-stage store source register
- rt_val_M  in  32  RT value latched in EX/MEM
- A3_FWD_E / Tnew_FWD_E / WD_FWD_E  in  5 / 2 / 32  ID/EX forwarding triple
- A3_FWD_M / Tnew_FWD_M / WD_FWD_M  in  5 / 2 / 32  EX/MEM forwarding triple
- A3_FWD_W / WD_FWD_W  in  5 / 32  MEM/WB triple (Tnew is 0 by definition)
- md_start_E  in  1  mult/div instr is in E this cycle
- md_is_div_E  in  1  1 = div/divu, 0 = mult/multu
- md_use_D  in  1  D instr is mult/div/mfhi/mflo/mthi/mtlo
- fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M  out  32 each  forwarded operands
- stall  out  1  freeze PC and IF/ID
- en_PC, en_D  out  1 each  = ~stall
- clr_E  out  1  = stall; inserts a bubble into ID/EX
- md_busy  out  1  mult/div unit busy

Behaviour:
- Register 0 is never forwarded and never causes a stall; A3 == 0 is treated as "no write".
- Forwarding is combinational.
  - Operand X in stage S takes the value from the youngest later stage (E > M > W) whose A3 == X and whose Tnew == 0.
  - If no stage matches, the original value passes through.
  - D operands may take from E, M or W; E operands from M or W; rt_M from W only.
- Data stall is combinational. It is asserted if, for rs_D or rt_D (nonzero):
  - A3_FWD_E == reg and Tnew_FWD_E > tuse, or
  - A3_FWD_M == reg and Tnew_FWD_M > tuse.
  - tuse = 3 never stalls.
- md counter (the only state):
  - cnt is CNT_W bits and resets to 0.
  - On an edge with md_start_E = 1: cnt <= md_is_div_E ? DIV_CYCLES : MULT_CYCLES. A start while busy reloads the counter.
  - Otherwise cnt decrements by 1 when nonzero and holds at 0.
  - md_busy = (cnt != 0).
- md stall = md_use_D & (md_start_E | md_busy).
- stall = data stall | md stall.
- While reset = 1:
  - stall, clr_E and md_busy are forced to 0; en_PC and en_D are forced to 1.
  - cnt clears at that edge.
  - Forwarding muxes stay live.
- Reset asserted mid-count aborts the count: md_busy = 0 in the first cycle after the edge.
- Latency: md_busy rises 1 cycle after md_start_E, stays high exactly N cycles, then falls.

Optional Feature:
- Macro HAZARD_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt [31:0], a free-running count of cycles with stall = 1.
  - Cleared by reset; wraps 0xFFFFFFFF -> 0.
  - Adds output md_stall_cnt [31:0], which counts md-stall cycles only, with the same rules.
- When undefined: neither port exists and the core logic is unchanged.

Test Plan:
- Forwarding from E: A3_FWD_E = 8, Tnew_FWD_E = 0, WD_FWD_E = 0x1234; A3_FWD_M = 8, WD_FWD_M = 0x5555; rs_D = 8 -> fwd_rs_D = 0x1234 (E wins), stall = 0.
- Load-use: A3_FWD_E = 9, Tnew_FWD_E = 2, rt_D = 9, tuse_rt_D = 1 -> stall = 1, clr_E = 1, en_PC = 0. Same inputs with tuse_rt_D = 2 -> stall = 0.
- Register 0: A3_FWD_M = 0, Tnew_FWD_M = 0, WD_FWD_M = 0xFFFF, rs_E = 0, rs_val_E = 0 -> fwd_rs_E = 0, no stall.
- Div busy:
  - Pulse md_start_E = 1, md_is_div_E = 1 for one cycle -> md_busy high exactly 10 cycles.
  - Hold md_use_D = 1 -> stall high 11 cycles (start cycle + 10), low on cycle 12.
- Reset mid-operation: mult start, then reset on cycle 3 -> md_busy = 0 after the reset edge, no stall.
  - With HAZARD_STALL_CNT_EN defined, stall_cnt reads 0 after that reset and increments once per stalled cycle.
